if_id_stage: RTL

- Fetch stage plus IF/ID pipeline register for the 5-stage MIPS pipeline.
- Holds the PC and presents it to the instruction memory. Registers the fetched instruction and PC+4 for the decode stage, where the control decoder reads op = instr[31:26] and funct = instr[5:0].
- Contains the load-use hazard detector.
- Applies stall and branch flush. Branches resolve in ID through the decoder's PCSrc.

---
 rtl/if_id_stage_if.sv | 28 ++
 rtl/if_id_stage.sv | 87 ++++++++
 2 files changed

// File: rtl/if_id_stage_if.sv
// Signal bundle between the fetch / IF-ID stage and its neighbours:
// instruction memory, ID-stage branch resolution and the ID/EX hazard inputs.
interface if_id_stage_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      instr_in;
    logic [31:0]      pc_out;
    logic             branch_taken;
    logic [31:0]      branch_target;
    logic             idex_memread;
    logic [4:0]       idex_rt;
    logic [31:0]      ifid_instr;
    logic [31:0]      ifid_pc4;
    logic             ifid_valid;
    logic             stall;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        input  instr_in, branch_taken, branch_target, idex_memread, idex_rt,
        output pc_out, ifid_instr, ifid_pc4, ifid_valid, stall, stall_cnt, flush_cnt
    );

    modport slave (
        output instr_in, branch_taken, branch_target, idex_memread, idex_rt,
        input  pc_out, ifid_instr, ifid_pc4, ifid_valid, stall, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/if_id_stage.sv
// Fetch PC plus IF/ID pipeline register for the 5-stage MIPS pipeline,
// with load-use hazard detection, branch flush and saturating event counters.
module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic          clk,
    input  logic          rst,
    if_id_stage_if.master bus
);

    logic [31:0]      r_pc;
    logic [31:0]      r_instr;
    logic [31:0]      r_pc4;
    logic             r_valid;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic        w_rt_is_src;
    logic        w_rs_hit;
    logic        w_rt_hit;
    logic        w_stall;
    logic [31:0] w_pc_plus4;

    assign w_op       = r_instr[31:26];
    assign w_rs       = r_instr[25:21];
    assign w_rt       = r_instr[20:16];
    assign w_pc_plus4 = r_pc + 32'd4;

    // rt is only read by R-type, beq, bne and sw; elsewhere it is a destination.
    always_comb begin
        w_rt_is_src = 1'b0;
        case (w_op)
            6'b000000,
            6'b000100,
            6'b000101,
            6'b101011: w_rt_is_src = 1'b1;
            default:   w_rt_is_src = 1'b0;
        endcase
    end

    assign w_rs_hit = (bus.idex_rt == w_rs);
    assign w_rt_hit = w_rt_is_src && (bus.idex_rt == w_rt);
    assign w_stall  = r_valid && bus.idex_memread && (bus.idex_rt != 5'd0)
                      && (w_rs_hit || w_rt_hit);

    // A stall outranks a branch: the branch in ID read stale operands and re-resolves next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_instr     <= 32'd0;
            r_pc4       <= 32'd0;
            r_valid     <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (w_stall) begin
            if (r_stall_cnt != '1) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end else if (bus.branch_taken) begin
            r_pc    <= bus.branch_target;
            r_instr <= 32'd0;
            r_pc4   <= 32'd0;
            r_valid <= 1'b0;
            if (r_flush_cnt != '1) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end else begin
            r_pc    <= w_pc_plus4;
            r_instr <= bus.instr_in;
            r_pc4   <= w_pc_plus4;
            r_valid <= 1'b1;
        end
    end

    assign bus.pc_out     = r_pc;
    assign bus.ifid_instr = r_instr;
    assign bus.ifid_pc4   = r_pc4;
    assign bus.ifid_valid = r_valid;
    assign bus.stall      = w_stall;
    assign bus.stall_cnt  = r_stall_cnt;
    assign bus.flush_cnt  = r_flush_cnt;

endmodule
